// File: rtl/mdu_param_pkg.sv
// Shared CPU definitions: ALU/forwarding selects plus the MDU op codes and FSM states.
package mdu_param_pkg;

  localparam int unsigned ALU_OP_W  = 4;
  localparam int unsigned MDU_OP_W  = 4;
  localparam int unsigned MDU_CNT_W = 6;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11
  } alu_op_e;

  typedef enum logic [1:0] {
    RFWD_NONE = 2'd0,
    RFWD_EX   = 2'd1,
    RFWD_MEM  = 2'd2,
    RFWD_WB   = 2'd3
  } rfwd_sel_e;

  typedef enum logic [MDU_OP_W-1:0] {
    MDU_NOP   = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MADD  = 4'd5,
    MDU_MADDU = 4'd6,
    MDU_MSUB  = 4'd7,
    MDU_MSUBU = 4'd8,
    MDU_MTHI  = 4'd9,
    MDU_MTLO  = 4'd10
  } mdu_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_RUN  = 2'd1
  } mdu_state_e;

  function automatic logic mdu_is_mul(input logic [MDU_OP_W-1:0] op);
    return op inside {MDU_MULT, MDU_MULTU, MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU};
  endfunction

  function automatic logic mdu_is_div(input logic [MDU_OP_W-1:0] op);
    return op inside {MDU_DIV, MDU_DIVU};
  endfunction

  function automatic logic mdu_is_signed(input logic [MDU_OP_W-1:0] op);
    return op inside {MDU_MULT, MDU_DIV, MDU_MADD, MDU_MSUB};
  endfunction

endpackage

// File: rtl/mdu_param_divider.sv
// Combinational signed/unsigned divider: quotient truncates toward zero, remainder follows dividend sign.
module mdu_divider
  import mdu_param_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             signed_i,
  output logic [WIDTH-1:0] quotient_c_o,
  output logic [WIDTH-1:0] remainder_c_o,
  output logic             div_zero_c_o
);

  logic             neg_a;
  logic             neg_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] quo_u;
  logic [WIDTH-1:0] rem_u;

  // MIN_INT magnitude wraps to itself, which is exactly 2^(WIDTH-1) unsigned
  always_comb begin
    neg_a        = signed_i & dividend_i[WIDTH-1];
    neg_b        = signed_i & divisor_i[WIDTH-1];
    mag_a        = neg_a ? (~dividend_i + WIDTH'(1)) : dividend_i;
    mag_b        = neg_b ? (~divisor_i + WIDTH'(1)) : divisor_i;
    div_zero_c_o = (divisor_i == '0);
    quo_u        = '0;
    rem_u        = '0;
    if (!div_zero_c_o) begin
      quo_u = mag_a / mag_b;
      rem_u = mag_a % mag_b;
    end
    quotient_c_o  = (neg_a ^ neg_b) ? (~quo_u + WIDTH'(1)) : quo_u;
    remainder_c_o = neg_a ? (~rem_u + WIDTH'(1)) : rem_u;
  end

endmodule

// File: rtl/mdu_param.sv
// Multiply/divide unit with HI/LO registers; fixed-latency multi-cycle ops tracked by a down-counter.
module mdu_param
  import mdu_param_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req,
  input  logic                start,
  input  logic [MDU_OP_W-1:0] op,
  input  logic [WIDTH-1:0]    rs_data,
  input  logic [WIDTH-1:0]    rt_data,
  output logic                busy,
  output logic [WIDTH-1:0]    hi,
  output logic [WIDTH-1:0]    lo
);

  localparam int unsigned PW = 2 * WIDTH;

  mdu_state_e           state_q, state_d;
  logic [MDU_CNT_W-1:0] cnt_q, cnt_d;
  logic [MDU_OP_W-1:0]  op_q, op_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 busy_q, busy_d;

  logic                 issue_c;
  logic                 sgn_c;
  logic [PW-1:0]        acc_c;
  logic [PW-1:0]        a_ext_c;
  logic [PW-1:0]        b_ext_c;
  logic [PW-1:0]        prod_c;
  logic [PW-1:0]        res_c;
  logic [WIDTH-1:0]     quo_c;
  logic [WIDTH-1:0]     rem_c;
  logic                 div_zero_c;

  mdu_divider #(.WIDTH(WIDTH)) u_div (
    .dividend_i    (a_q),
    .divisor_i     (b_q),
    .signed_i      (sgn_c),
    .quotient_c_o  (quo_c),
    .remainder_c_o (rem_c),
    .div_zero_c_o  (div_zero_c)
  );

  // Sign/zero extension to 2*WIDTH makes a plain product exact modulo 2^(2*WIDTH)
  always_comb begin
    sgn_c   = mdu_is_signed(op_q);
    acc_c   = {hi_q, lo_q};
    a_ext_c = {{WIDTH{sgn_c & a_q[WIDTH-1]}}, a_q};
    b_ext_c = {{WIDTH{sgn_c & b_q[WIDTH-1]}}, b_q};
    prod_c  = a_ext_c * b_ext_c;
    res_c   = acc_c;
    case (op_q)
      MDU_MULT, MDU_MULTU: res_c = prod_c;
      MDU_MADD, MDU_MADDU: res_c = acc_c + prod_c;
      MDU_MSUB, MDU_MSUBU: res_c = acc_c - prod_c;
      MDU_DIV,  MDU_DIVU:  res_c = div_zero_c ? acc_c : {rem_c, quo_c};
      default:             res_c = acc_c;
    endcase
  end

  assign issue_c = start & ~req & ~busy_q & (state_q == MDU_IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    case (state_q)
      MDU_IDLE: begin
        if (issue_c) begin
          if (op == MDU_MTHI) begin
            hi_d = rs_data;
          end else if (op == MDU_MTLO) begin
            lo_d = rs_data;
          end else if (mdu_is_mul(op) || mdu_is_div(op)) begin
            state_d = MDU_RUN;
            busy_d  = 1'b1;
            cnt_d   = mdu_is_mul(op) ? MDU_CNT_W'(MUL_LAT) : MDU_CNT_W'(DIV_LAT);
            op_d    = op;
            a_d     = rs_data;
            b_d     = rt_data;
          end
        end
      end
      MDU_RUN: begin
        cnt_d = cnt_q - MDU_CNT_W'(1);
        if (cnt_q == MDU_CNT_W'(1)) begin
          state_d      = MDU_IDLE;
          busy_d       = 1'b0;
          {hi_d, lo_d} = res_c;
        end
      end
      default: begin
        state_d = MDU_IDLE;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= MDU_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_param.sv
// Scoreboard bench: stimulus queues expected HI/LO/latency, monitors check on each busy falling edge.
module tb_mdu_param;
  import mdu_param_pkg::*;

  typedef struct {
    int          tag;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b1;
  logic        req_a = 1'b0, start_a = 1'b0;
  logic [3:0]  op_a = 4'd0;
  logic [31:0] rs_a = '0, rt_a = '0;
  logic        busy_a;
  logic [31:0] hi_a, lo_a;

  logic        req_b = 1'b0, start_b = 1'b0;
  logic [3:0]  op_b = 4'd0;
  logic [15:0] rs_b = '0, rt_b = '0;
  logic        busy_b;
  logic [15:0] hi_b, lo_b;

  int   n_chk = 0;
  int   n_pass = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b;
  int   run_a = 0, run_b = 0;
  logic prev_a = 1'b0, prev_b = 1'b0;

  mdu_param dut_a (
    .clk(clk), .reset(rst_n), .req(req_a), .start(start_a), .op(op_a),
    .rs_data(rs_a), .rt_data(rt_a), .busy(busy_a), .hi(hi_a), .lo(lo_a)
  );

  mdu_param #(.WIDTH(16), .MUL_LAT(5), .DIV_LAT(1)) dut_b (
    .clk(clk), .reset(rst_n), .req(req_b), .start(start_b), .op(op_b),
    .rs_data(rs_b), .rt_data(rt_b), .busy(busy_b), .hi(hi_b), .lo(lo_b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic exp_t mk(input int tag, input logic [31:0] h, input logic [31:0] l, input int lat);
    exp_t e;
    e.tag = tag; e.hi = h; e.lo = l; e.lat = lat;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      run_a  = 0;
      prev_a = 1'b0;
    end else begin
      if (busy_a) run_a++;
      else if (prev_a) begin
        if (q_a.size() == 0) chk("A unexpected completion", 32'd1, 32'd0);
        else begin
          e_a = q_a.pop_front();
          chk($sformatf("A op%0d hi", e_a.tag), hi_a, e_a.hi);
          chk($sformatf("A op%0d lo", e_a.tag), lo_a, e_a.lo);
          chk($sformatf("A op%0d busy cycles", e_a.tag), 32'(run_a), 32'(e_a.lat));
        end
        run_a = 0;
      end
      prev_a = busy_a;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      run_b  = 0;
      prev_b = 1'b0;
    end else begin
      if (busy_b) run_b++;
      else if (prev_b) begin
        if (q_b.size() == 0) chk("B unexpected completion", 32'd1, 32'd0);
        else begin
          e_b = q_b.pop_front();
          chk($sformatf("B op%0d hi", e_b.tag), {16'h0, hi_b}, e_b.hi);
          chk($sformatf("B op%0d lo", e_b.tag), {16'h0, lo_b}, e_b.lo);
          chk($sformatf("B op%0d busy cycles", e_b.tag), 32'(run_b), 32'(e_b.lat));
        end
        run_b = 0;
      end
      prev_b = busy_b;
    end
  end

  task automatic issue_a(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input logic r);
    @(posedge clk); #1;
    op_a = o; rs_a = a; rt_a = b; req_a = r; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; req_a = 1'b0;
  endtask

  task automatic issue_b(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b);
    @(posedge clk); #1;
    op_b = o; rs_b = a; rt_b = b; start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
  endtask

  task automatic wait_a();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy_a) return;
    end
    n_chk++;
    $display("FAIL A wait_idle: busy still %b after 100 cycles, required 0", busy_a);
  endtask

  task automatic wait_b();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy_b) return;
    end
    n_chk++;
    $display("FAIL B wait_idle: busy still %b after 100 cycles, required 0", busy_b);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("reset busy", {31'd0, busy_a}, 32'd0);
    chk("reset hi", hi_a, 32'd0);
    chk("reset lo", lo_a, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // 16-bit instance with single-cycle divide
    q_b.push_back(mk(1, 32'h0000, 32'h8000, 1));
    issue_b(MDU_DIV, 16'h8000, 16'hFFFF);
    wait_b();
    q_b.push_back(mk(2, 32'h8000, 32'h0000, 1));
    issue_b(MDU_DIVU, 16'h8000, 16'hFFFF);
    wait_b();
    q_b.push_back(mk(3, 32'h0000, 32'h0001, 5));
    issue_b(MDU_MULT, 16'hFFFF, 16'hFFFF);
    wait_b();

    q_a.push_back(mk(1, 32'hFFFFFFFF, 32'hFFFFFFFE, 5));
    issue_a(MDU_MULT, 32'hFFFFFFFF, 32'd2, 1'b0);
    wait_a();
    q_a.push_back(mk(2, 32'h00000001, 32'hFFFFFFFE, 5));
    issue_a(MDU_MULTU, 32'hFFFFFFFF, 32'd2, 1'b0);
    wait_a();
    q_a.push_back(mk(3, 32'hFFFFFFFF, 32'hFFFFFFFD, 10));
    issue_a(MDU_DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
    wait_a();
    q_a.push_back(mk(4, 32'hFFFFFFFF, 32'hFFFFFFFD, 10));
    issue_a(MDU_DIVU, 32'd7, 32'd0, 1'b0);
    wait_a();
    q_a.push_back(mk(5, 32'h00000001, 32'hFFFFFFFD, 10));
    issue_a(MDU_DIV, 32'd7, 32'hFFFFFFFE, 1'b0);
    wait_a();
    q_a.push_back(mk(6, 32'h00000000, 32'h80000000, 10));
    issue_a(MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    wait_a();

    issue_a(MDU_MTHI, 32'd5, 32'd0, 1'b0);
    chk("MTHI busy", {31'd0, busy_a}, 32'd0);
    chk("MTHI hi", hi_a, 32'd5);
    chk("MTHI lo kept", lo_a, 32'h80000000);
    issue_a(MDU_MTLO, 32'd3, 32'd0, 1'b0);
    chk("MTLO lo", lo_a, 32'd3);
    chk("MTLO hi kept", hi_a, 32'd5);

    q_a.push_back(mk(9, 32'd5, 32'd11, 5));
    issue_a(MDU_MADDU, 32'd2, 32'd4, 1'b0);
    wait_a();
    q_a.push_back(mk(10, 32'd4, 32'hFFFFFFFF, 5));
    issue_a(MDU_MSUB, 32'd1, 32'd12, 1'b0);
    wait_a();

    issue_a(MDU_MULT, 32'd3, 32'd3, 1'b1);
    @(negedge clk);
    chk("req-blocked busy", {31'd0, busy_a}, 32'd0);
    chk("req-blocked hi", hi_a, 32'd4);
    chk("req-blocked lo", lo_a, 32'hFFFFFFFF);
    issue_a(4'd15, 32'd9, 32'd9, 1'b0);
    @(negedge clk);
    chk("nop busy", {31'd0, busy_a}, 32'd0);
    chk("nop lo", lo_a, 32'hFFFFFFFF);

    // start held during busy with new operands must be ignored
    q_a.push_back(mk(12, 32'd0, 32'd15, 5));
    issue_a(MDU_MULTU, 32'd3, 32'd5, 1'b0);
    op_a = MDU_MTHI; rs_a = 32'hAA; rt_a = 32'h77; start_a = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start_a = 1'b0;
    wait_a();

    q_a.push_back(mk(13, 32'd2, 32'd14, 10));
    issue_a(MDU_DIV, 32'd100, 32'd7, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    req_a = 1'b1; rs_a = '0; rt_a = '0;
    @(posedge clk); #1 req_a = 1'b0;
    wait_a();
    q_a.push_back(mk(14, 32'd2, 32'd8, 5));
    issue_a(MDU_MADD, 32'hFFFFFFFE, 32'd3, 1'b0);
    wait_a();
    q_a.push_back(mk(15, 32'd1, 32'd9, 5));
    issue_a(MDU_MSUBU, 32'hFFFFFFFF, 32'd1, 1'b0);
    wait_a();

    // reset in the middle of a multiply discards it
    issue_a(MDU_MULT, 32'd7, 32'd7, 1'b0);
    repeat (3) @(negedge clk);
    chk("pre-reset busy", {31'd0, busy_a}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset busy", {31'd0, busy_a}, 32'd0);
    chk("async reset hi", hi_a, 32'd0);
    chk("async reset lo", lo_a, 32'd0);
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    q_a.push_back(mk(17, 32'd0, 32'd9, 5));
    issue_a(MDU_MULT, 32'd3, 32'd3, 1'b0);
    wait_a();

    repeat (3) @(negedge clk);
    chk("A queue drained", 32'(q_a.size()), 32'd0);
    chk("B queue drained", 32'(q_b.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mdu_param.md
MDU_PARAM -- requirements
Module: mdu_param

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand and HI/LO width in bits (legal range 8..64).
REQ-002 SHALL have parameter MUL_LAT, default 5, meaning busy cycles for multiply-class ops (legal range 1..31).
REQ-003 SHALL have parameter DIV_LAT, default 10, meaning busy cycles for divide-class ops (legal range 1..63).
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req  input  1  exception/interrupt request from CP0; blocks any start in the same cycle.
REQ-007 SHALL have port start  input  1  op issue strobe, sampled every cycle.
REQ-008 SHALL have port op  input  4  operation code from the shared package.
REQ-009 SHALL have port rs_data  input  WIDTH  operand A, already forwarded.
REQ-010 SHALL have port rt_data  input  WIDTH  operand B, already forwarded.
REQ-011 SHALL have port busy  output  1  high while a multi-cycle op is in flight.
REQ-012 SHALL have port hi  output  WIDTH  architectural HI register.
REQ-013 SHALL have port lo  output  WIDTH  architectural LO register.

Function
REQ-014 SHALL support the ops MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU, MTHI and MTLO; any other code SHALL be a no-op.
REQ-015 SHALL accept an issue only when start=1, req=0, busy=0 and the 2-bit FSM is in IDLE; an issue attempted while busy or with req=1 SHALL be dropped without side effects.
REQ-016 SHALL, on MTHI or MTLO, write rs_data into hi or lo respectively at the issuing edge, without asserting busy.
REQ-017 SHALL, on a multiply-class op, enter RUN with the counter loaded to MUL_LAT; on a divide-class op, enter RUN with the counter loaded to DIV_LAT.
REQ-018 SHALL hold busy=1 for exactly MUL_LAT or DIV_LAT cycles, starting the cycle after the issue edge.
REQ-019 SHALL update hi and lo only at the edge on which the counter reaches zero; busy SHALL then fall and the FSM SHALL return to IDLE.
REQ-020 SHALL make the next issue legal in the cycle after busy falls.
REQ-021 SHALL compute MULT/MULTU as {hi,lo} = the full 2*WIDTH-bit signed/unsigned product of the operands latched at issue.
REQ-022 SHALL compute MADD(U) as {hi,lo} += product and MSUB(U) as {hi,lo} -= product, modulo 2^(2*WIDTH).
REQ-023 SHALL use, for MADD/MSUB, the {hi,lo} value held at the issue edge.
REQ-024 SHALL compute DIV/DIVU as lo = quotient truncated toward zero and hi = remainder carrying the sign of the dividend.
REQ-025 SHALL, on a divide by zero, still run DIV_LAT busy cycles and leave hi and lo unchanged.
REQ-026 SHALL, for signed MIN_INT / -1, produce lo = MIN_INT and hi = 0 with no trap.
REQ-027 SHALL latch operands at issue; rs_data and rt_data changes while busy SHALL not affect the result.
REQ-028 SHALL let an in-flight op complete normally when req is asserted while busy (the issuing instruction has already committed).
REQ-029 SHALL leave hi, lo and busy unaffected by start=1 while busy=1.

Reset
REQ-030 SHALL, while reset=0, asynchronously force hi=0, lo=0, busy=0, counter=0 and FSM=IDLE.
REQ-031 SHALL, on reset mid-operation, discard the pending result; the first issue after reset release SHALL be accepted normally.

Structure
REQ-032 SHALL take op encodings (MDU_MULT...MDU_MTLO) and the FSM state constants (IDLE, RUN) from the shared CPU package, alongside the existing ALU/RFWD defines.
REQ-033 SHALL instantiate one sub-module, mdu_divider (combinational or iterative; WIDTH-parametrised, signed and unsigned, quotient and remainder), with multiplication inline.
REQ-034 SHALL not let busy depend combinationally on start; the stall unit combines start and busy externally.

Verification
REQ-035 SHALL verify: WIDTH=32, MULT with rs=0xFFFFFFFF, rt=2 -> busy high for cycles 1..5; after cycle 5 hi=0xFFFFFFFF, lo=0xFFFFFFFE.
REQ-036 SHALL verify: DIV with rs=-7, rt=2 -> after 10 busy cycles lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU with rs=7, rt=0 -> hi and lo unchanged.
REQ-037 SHALL verify: MTHI 5, MTLO 3, then MADDU with rs=2, rt=4 -> hi=5, lo=11; then MSUB with rs=1, rt=12 -> hi=4, lo=0xFFFFFFFF.
REQ-038 SHALL verify: start and req both high on a MULT -> busy stays 0 and hi/lo are unchanged; req pulsed mid-DIV -> the DIV result is still written.
REQ-039 SHALL verify: reset driven low at busy cycle 3 of a MULT -> busy=0, hi=0 and lo=0 immediately with no clock edge; MULT 3*3 after release -> lo=9.
REQ-040 SHALL verify: WIDTH=16, DIV_LAT=1, DIV with 0x8000 / 0xFFFF -> lo=0x8000, hi=0, and busy high for exactly 1 cycle.
